// File: rtl/iob_eth_bd_sched_pkg.sv
// Shared buffer-descriptor layout, word selects, FSM states and channel encoding
// for the Ethernet DMA descriptor scheduler.
package iob_eth_bd_sched_pkg;

    localparam int unsigned BD_W      = 32;
    localparam int unsigned LEN_MSB   = 31;
    localparam int unsigned LEN_LSB   = 16;
    localparam int unsigned LEN_FLD_W = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned READY_BIT = 15;
    localparam int unsigned IRQ_BIT   = 14;
    localparam int unsigned WRAP_BIT  = 13;
    localparam int unsigned ERR_BIT   = 0;

    localparam logic WORD0 = 1'b0;
    localparam logic WORD1 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        CHK0,
        RD1,
        CHK1,
        DISP,
        WAIT,
        WB
    } state_t;

    typedef enum logic {
        CH_TX = 1'b0,
        CH_RX = 1'b1
    } chan_t;

    // Status word: new length, ownership handed back, flags kept, error reported
    function automatic logic [BD_W-1:0] wb_word(input logic [LEN_FLD_W-1:0] len,
                                                input logic [BD_W-1:0]      w0,
                                                input logic                 err);
        logic [BD_W-1:0] w;
        w                   = w0;
        w[LEN_MSB:LEN_LSB]  = len;
        w[READY_BIT]        = 1'b0;
        w[ERR_BIT]          = err;
        return w;
    endfunction

endpackage

// File: rtl/iob_eth_bd_sched_ring_ptr.sv
// Ring index tracker: base/last of one descriptor ring, advance with wrap,
// and reload to the ring base on an enable rising edge.
module iob_eth_bd_ring_ptr #(
    parameter int unsigned BD_ADDR_W = 8,
    parameter bit          IS_RX     = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    input  logic                 en_i,
    input  logic [BD_ADDR_W-1:0] tx_bd_num_i,
    input  logic                 adv_i,
    input  logic                 wrap_i,
    output logic [BD_ADDR_W-2:0] idx_o,
    output logic                 avail_c
);

    localparam int unsigned IDX_W = BD_ADDR_W - 1;
    localparam logic [BD_ADDR_W-1:0] RING_SIZE = BD_ADDR_W'(1 << IDX_W);

    logic             en_q;
    logic [IDX_W-1:0] base_c;
    logic [IDX_W-1:0] last_c;
    logic             nonempty_c;

    always_comb begin
        base_c     = IS_RX ? tx_bd_num_i[IDX_W-1:0] : '0;
        last_c     = IS_RX ? '1 : IDX_W'(tx_bd_num_i - BD_ADDR_W'(1));
        nonempty_c = IS_RX ? (tx_bd_num_i != RING_SIZE) : (tx_bd_num_i != '0);
        // Wait one cycle after the enable edge so the reloaded index is used
        avail_c    = en_i & en_q & nonempty_c;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            en_q  <= 1'b0;
            idx_o <= '0;
        end else if (cke_i) begin
            en_q <= en_i;
            if (en_i && !en_q) begin
                idx_o <= base_c;
            end else if (adv_i) begin
                idx_o <= (wrap_i || idx_o == last_c) ? base_c : idx_o + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/iob_eth_bd_sched.sv
// Buffer-descriptor scheduler: walks TX/RX descriptor rings on BD RAM port B,
// dispatches one job at a time to the movers and writes status back.
module iob_eth_bd_sched
    import iob_eth_bd_sched_pkg::*;
#(
    parameter int unsigned BD_ADDR_W = 8,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 cke_i,
    input  logic                 tx_en_i,
    input  logic                 rx_en_i,
    input  logic [BD_ADDR_W-1:0] tx_bd_num_i,
    output logic                 bd_en_o,
    output logic                 bd_wen_o,
    output logic [BD_ADDR_W-1:0] bd_addr_o,
    output logic [31:0]          bd_o,
    input  logic [31:0]          bd_i,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [31:0]          tx_ptr_o,
    output logic [LEN_W-1:0]     tx_len_o,
    input  logic                 tx_done_i,
    input  logic                 tx_err_i,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [31:0]          rx_ptr_o,
    input  logic                 rx_done_i,
    input  logic                 rx_err_i,
    input  logic [LEN_W-1:0]     rx_len_i,
    output logic                 tx_irq_o,
    output logic                 rx_irq_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = BD_ADDR_W - 1;

    state_t            state;
    chan_t             ch;
    chan_t             prio;
    logic [BD_W-1:0]   w0;
    logic              done_pend;
    logic              err_pend;
    logic [LEN_W-1:0]  len_pend;
    logic              bd_en_q;
    logic              bd_wen_q;

    logic [IDX_W-1:0]  tx_idx;
    logic [IDX_W-1:0]  rx_idx;
    logic [IDX_W-1:0]  cur_idx_c;
    logic              tx_av_c;
    logic              rx_av_c;
    logic              tx_adv_c;
    logic              rx_adv_c;
    logic              ready_c;
    logic              done_c;
    logic              err_c;
    logic              fin_c;
    logic              fin_err_c;
    logic [LEN_W-1:0]  fin_len_c;
    logic [LEN_FLD_W-1:0] wb_len_c;

    iob_eth_bd_ring_ptr #(.BD_ADDR_W(BD_ADDR_W), .IS_RX(1'b0)) u_tx_ring (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .cke_i       (cke_i),
        .en_i        (tx_en_i),
        .tx_bd_num_i (tx_bd_num_i),
        .adv_i       (tx_adv_c),
        .wrap_i      (w0[WRAP_BIT]),
        .idx_o       (tx_idx),
        .avail_c     (tx_av_c)
    );

    iob_eth_bd_ring_ptr #(.BD_ADDR_W(BD_ADDR_W), .IS_RX(1'b1)) u_rx_ring (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .cke_i       (cke_i),
        .en_i        (rx_en_i),
        .tx_bd_num_i (tx_bd_num_i),
        .adv_i       (rx_adv_c),
        .wrap_i      (w0[WRAP_BIT]),
        .idx_o       (rx_idx),
        .avail_c     (rx_av_c)
    );

    // Per-channel views of the active job; a done seen with ready is kept pending
    always_comb begin
        cur_idx_c = (ch == CH_TX) ? tx_idx     : rx_idx;
        ready_c   = (ch == CH_TX) ? tx_ready_i : rx_ready_i;
        done_c    = (ch == CH_TX) ? tx_done_i  : rx_done_i;
        err_c     = (ch == CH_TX) ? tx_err_i   : rx_err_i;
        fin_c     = done_pend | done_c;
        fin_err_c = done_pend ? err_pend : err_c;
        fin_len_c = done_pend ? len_pend : rx_len_i;
        wb_len_c  = (ch == CH_TX) ? w0[LEN_MSB:LEN_LSB] : LEN_FLD_W'(fin_len_c);
        tx_adv_c  = (state == WB) && (ch == CH_TX);
        rx_adv_c  = (state == WB) && (ch == CH_RX);
    end

    assign bd_en_o  = bd_en_q & cke_i;
    assign bd_wen_o = bd_wen_q & cke_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state      <= IDLE;
            ch         <= CH_TX;
            prio       <= CH_TX;
            w0         <= '0;
            done_pend  <= 1'b0;
            err_pend   <= 1'b0;
            len_pend   <= '0;
            bd_en_q    <= 1'b0;
            bd_wen_q   <= 1'b0;
            bd_addr_o  <= '0;
            bd_o       <= '0;
            tx_valid_o <= 1'b0;
            tx_ptr_o   <= '0;
            tx_len_o   <= '0;
            rx_valid_o <= 1'b0;
            rx_ptr_o   <= '0;
            tx_irq_o   <= 1'b0;
            rx_irq_o   <= 1'b0;
            busy_o     <= 1'b0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (tx_av_c && (prio == CH_TX || !rx_av_c)) begin
                        ch        <= CH_TX;
                        bd_addr_o <= {tx_idx, WORD0};
                        bd_en_q   <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= RD0;
                    end else if (rx_av_c) begin
                        ch        <= CH_RX;
                        bd_addr_o <= {rx_idx, WORD0};
                        bd_en_q   <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= RD0;
                    end
                end
                RD0: begin
                    bd_en_q <= 1'b0;
                    state   <= CHK0;
                end
                CHK0: begin
                    w0 <= bd_i;
                    if (!bd_i[READY_BIT]) begin
                        prio   <= (prio == CH_TX) ? CH_RX : CH_TX;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        bd_addr_o <= {cur_idx_c, WORD1};
                        bd_en_q   <= 1'b1;
                        state     <= RD1;
                    end
                end
                RD1: begin
                    bd_en_q <= 1'b0;
                    state   <= CHK1;
                end
                CHK1: begin
                    done_pend <= 1'b0;
                    if (ch == CH_TX) begin
                        tx_ptr_o   <= bd_i;
                        tx_len_o   <= LEN_W'(w0[LEN_MSB:LEN_LSB]);
                        tx_valid_o <= 1'b1;
                    end else begin
                        rx_ptr_o   <= bd_i;
                        rx_valid_o <= 1'b1;
                    end
                    state <= DISP;
                end
                DISP: begin
                    if (ready_c) begin
                        tx_valid_o <= 1'b0;
                        rx_valid_o <= 1'b0;
                        if (done_c) begin
                            done_pend <= 1'b1;
                            err_pend  <= err_c;
                            len_pend  <= rx_len_i;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (fin_c) begin
                        bd_en_q   <= 1'b1;
                        bd_wen_q  <= 1'b1;
                        bd_addr_o <= {cur_idx_c, WORD0};
                        bd_o      <= wb_word(wb_len_c, w0, fin_err_c);
                        tx_irq_o  <= (ch == CH_TX) && w0[IRQ_BIT];
                        rx_irq_o  <= (ch == CH_RX) && w0[IRQ_BIT];
                        state     <= WB;
                    end
                end
                WB: begin
                    bd_en_q   <= 1'b0;
                    bd_wen_q  <= 1'b0;
                    tx_irq_o  <= 1'b0;
                    rx_irq_o  <= 1'b0;
                    done_pend <= 1'b0;
                    prio      <= (prio == CH_TX) ? CH_RX : CH_TX;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_bd_sched.sv
// Directed bench for iob_eth_bd_sched with a behavioural BD RAM and
// hand-driven TX/RX movers.
module tb_iob_eth_bd_sched;

    localparam int unsigned BD_ADDR_W = 8;
    localparam int unsigned LEN_W     = 16;

    logic                 clk_i = 1'b0;
    logic                 arst_i = 1'b1;
    logic                 cke_i = 1'b1;
    logic                 tx_en_i = 1'b0;
    logic                 rx_en_i = 1'b0;
    logic [BD_ADDR_W-1:0] tx_bd_num_i = 8'd2;
    logic                 bd_en_o;
    logic                 bd_wen_o;
    logic [BD_ADDR_W-1:0] bd_addr_o;
    logic [31:0]          bd_o;
    logic [31:0]          bd_i;
    logic                 tx_valid_o;
    logic                 tx_ready_i = 1'b0;
    logic [31:0]          tx_ptr_o;
    logic [LEN_W-1:0]     tx_len_o;
    logic                 tx_done_i = 1'b0;
    logic                 tx_err_i = 1'b0;
    logic                 rx_valid_o;
    logic                 rx_ready_i = 1'b0;
    logic [31:0]          rx_ptr_o;
    logic                 rx_done_i = 1'b0;
    logic                 rx_err_i = 1'b0;
    logic [LEN_W-1:0]     rx_len_i = '0;
    logic                 tx_irq_o;
    logic                 rx_irq_o;
    logic                 busy_o;

    iob_eth_bd_sched #(.BD_ADDR_W(BD_ADDR_W), .LEN_W(LEN_W)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .cke_i       (cke_i),
        .tx_en_i     (tx_en_i),
        .rx_en_i     (rx_en_i),
        .tx_bd_num_i (tx_bd_num_i),
        .bd_en_o     (bd_en_o),
        .bd_wen_o    (bd_wen_o),
        .bd_addr_o   (bd_addr_o),
        .bd_o        (bd_o),
        .bd_i        (bd_i),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .tx_ptr_o    (tx_ptr_o),
        .tx_len_o    (tx_len_o),
        .tx_done_i   (tx_done_i),
        .tx_err_i    (tx_err_i),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .rx_ptr_o    (rx_ptr_o),
        .rx_done_i   (rx_done_i),
        .rx_err_i    (rx_err_i),
        .rx_len_i    (rx_len_i),
        .tx_irq_o    (tx_irq_o),
        .rx_irq_o    (rx_irq_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // BD RAM model with a bench-side load port
    logic [31:0] mem [256];
    logic [31:0] bd_rd = '0;
    logic        tb_wr = 1'b0;
    logic        tb_clr = 1'b0;
    logic [7:0]  tb_waddr = '0;
    logic [31:0] tb_wdata = '0;
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          val_cnt = 0;

    assign bd_i = bd_rd;

    always @(posedge clk_i) begin
        if (tb_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
        if (tb_wr) mem[tb_waddr] <= tb_wdata;
        if (bd_en_o) begin
            if (bd_wen_o) begin
                mem[bd_addr_o] <= bd_o;
                wr_cnt <= wr_cnt + 1;
            end
            bd_rd  <= mem[bd_addr_o];
            en_cnt <= en_cnt + 1;
        end
        if (tx_valid_o || rx_valid_o) val_cnt <= val_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
        tick();
        tb_wr = 1'b0;
    endtask

    task automatic pulse_rst();
        arst_i = 1'b1;
        tick();
        arst_i = 1'b0;
    endtask

    // Returns the word address of the next word0 read, or all ones on timeout
    task automatic wait_fetch(output logic [31:0] a);
        int n;
        n = 0;
        while (!(bd_en_o && !bd_wen_o && !bd_addr_o[0]) && n < 60) begin
            tick();
            n++;
        end
        a = (n < 60) ? 32'(bd_addr_o) : 32'hFFFF_FFFF;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic job(input bit rx, input logic [31:0] ptr, input logic [15:0] len,
                       input bit err, input logic [15:0] rlen, input logic [7:0] addr,
                       input logic [31:0] wb, input bit irq, input bit drop, input string tag);
        int n;
        n = 0;
        while (!(rx ? rx_valid_o : tx_valid_o) && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(rx ? rx_valid_o : tx_valid_o), 32'd1);
        check({tag, "_other_valid"}, 32'(rx ? tx_valid_o : rx_valid_o), 32'd0);
        check({tag, "_ptr"}, rx ? rx_ptr_o : tx_ptr_o, ptr);
        if (!rx) check({tag, "_len"}, 32'(tx_len_o), 32'(len));
        if (rx) rx_ready_i = 1'b1; else tx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0; tx_ready_i = 1'b0;
        if (drop) tx_en_i = 1'b0;
        if (rx) begin
            rx_done_i = 1'b1; rx_err_i = err; rx_len_i = rlen;
        end else begin
            tx_done_i = 1'b1; tx_err_i = err;
        end
        tick();
        rx_done_i = 1'b0; rx_err_i = 1'b0; tx_done_i = 1'b0; tx_err_i = 1'b0;
        n = 0;
        while (!bd_wen_o && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_wb_wen"}, 32'(bd_wen_o), 32'd1);
        check({tag, "_wb_addr"}, 32'(bd_addr_o), 32'(addr));
        check({tag, "_wb_data"}, bd_o, wb);
        check({tag, "_irq"}, 32'(rx ? rx_irq_o : tx_irq_o), 32'(irq));
        check({tag, "_other_irq"}, 32'(rx ? tx_irq_o : rx_irq_o), 32'd0);
        tick();
        check({tag, "_irq_pulse"}, 32'(tx_irq_o | rx_irq_o), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int snap_en, snap_wr, snap_val;

        tb_clr = 1'b1;
        tick();
        tb_clr = 1'b0;
        tick();

        // Reset state
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_bd_en", 32'(bd_en_o), 32'd0);
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
        check("rst_addr", 32'(bd_addr_o), 32'd0);
        arst_i = 1'b0;

        // Single TX BD with IRQ and WRAP
        poke(8'd0, 32'h0040_E000);
        poke(8'd1, 32'h0000_1000);
        tx_en_i = 1'b1;
        wait_fetch(a);
        check("t2_rd0_addr", a, 32'd0);
        repeat (3) tick();
        check("t2_valid_n3", 32'(tx_valid_o), 32'd0);
        tick();
        check("t2_valid_n4", 32'(tx_valid_o), 32'd1);
        job(1'b0, 32'h1000, 16'd64, 1'b0, 16'd0, 8'd0, 32'h0040_6000, 1'b1, 1'b0, "t2");
        wait_fetch(a);
        check("t2_wrap_idx", a, 32'd0);
        tx_en_i = 1'b0;
        wait_idle("t2_idle");
        check("t2_mem", mem[0], 32'h0040_6000);

        // RX BD at index 2, error and received length written back
        poke(8'd4, 32'h0000_8000);
        poke(8'd5, 32'h0000_2000);
        rx_en_i = 1'b1;
        wait_fetch(a);
        check("t3_rd0_addr", a, 32'd4);
        job(1'b1, 32'h2000, 16'd0, 1'b1, 16'h05EA, 8'd4, 32'h05EA_0001, 1'b0, 1'b0, "t3");
        wait_fetch(a);
        check("t3_next_idx", a, 32'd6);
        rx_en_i = 1'b0;
        wait_idle("t3_idle");

        // Both rings owned: strict TX/RX alternation
        pulse_rst();
        poke(8'd0, 32'h0010_8000); poke(8'd1, 32'h0000_0100);
        poke(8'd2, 32'h0020_A000); poke(8'd3, 32'h0000_0200);
        poke(8'd4, 32'h0000_8000); poke(8'd5, 32'h0000_0300);
        poke(8'd6, 32'h0000_A000); poke(8'd7, 32'h0000_0400);
        tx_en_i = 1'b1;
        rx_en_i = 1'b1;
        job(1'b0, 32'h100, 16'h10, 1'b0, 16'd0,  8'd0, 32'h0010_0000, 1'b0, 1'b0, "t4a");
        job(1'b1, 32'h300, 16'd0,  1'b0, 16'h40, 8'd4, 32'h0040_0000, 1'b0, 1'b0, "t4b");
        job(1'b0, 32'h200, 16'h20, 1'b0, 16'd0,  8'd2, 32'h0020_2000, 1'b0, 1'b0, "t4c");
        job(1'b1, 32'h400, 16'd0,  1'b0, 16'h80, 8'd6, 32'h0080_2000, 1'b0, 1'b0, "t4d");
        snap_en = en_cnt; snap_wr = wr_cnt; snap_val = val_cnt;
        repeat (40) tick();
        check("t4_unowned_writes", 32'(wr_cnt - snap_wr), 32'd0);
        check("t4_unowned_dispatch", 32'(val_cnt - snap_val), 32'd0);
        check("t4_unowned_fetching", 32'(en_cnt != snap_en), 32'd1);
        tx_en_i = 1'b0;
        rx_en_i = 1'b0;
        wait_idle("t4_idle");

        // Three-entry TX ring without WRAP bits
        pulse_rst();
        tx_bd_num_i = 8'd3;
        poke(8'd0, 32'h0008_8000); poke(8'd1, 32'h0000_0010);
        poke(8'd2, 32'h0008_8000); poke(8'd3, 32'h0000_0020);
        poke(8'd4, 32'h0008_8000); poke(8'd5, 32'h0000_0030);
        tx_en_i = 1'b1;
        job(1'b0, 32'h10, 16'd8, 1'b0, 16'd0, 8'd0, 32'h0008_0000, 1'b0, 1'b0, "t5a");
        job(1'b0, 32'h20, 16'd8, 1'b0, 16'd0, 8'd2, 32'h0008_0000, 1'b0, 1'b0, "t5b");
        job(1'b0, 32'h30, 16'd8, 1'b0, 16'd0, 8'd4, 32'h0008_0000, 1'b0, 1'b0, "t5c");
        wait_fetch(a);
        check("t5_wrap_idx", a, 32'd0);
        tx_en_i = 1'b0;
        wait_idle("t5_idle");

        // Reset while a job is in WAIT
        pulse_rst();
        tx_bd_num_i = 8'd2;
        poke(8'd0, 32'h0004_C000); poke(8'd1, 32'h0000_0050);
        poke(8'd2, 32'h0006_8000); poke(8'd3, 32'h0000_0060);
        tx_en_i = 1'b1;
        job(1'b0, 32'h50, 16'd4, 1'b0, 16'd0, 8'd0, 32'h0004_4000, 1'b1, 1'b0, "t6a");
        for (int n = 0; n < 60 && !tx_valid_o; n++) tick();
        check("t6_idx1_ptr", tx_ptr_o, 32'h60);
        tx_ready_i = 1'b1;
        tick();
        tx_ready_i = 1'b0;
        snap_wr = wr_cnt;
        arst_i = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_valid", 32'(tx_valid_o), 32'd0);
        check("t6_rst_bd_en", 32'({bd_en_o, bd_wen_o}), 32'd0);
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        tick();
        arst_i = 1'b0;
        check("t6_no_wb", 32'(wr_cnt - snap_wr), 32'd0);
        check("t6_bd1_kept", mem[2], 32'h0006_8000);
        wait_fetch(a);
        check("t6_post_rst_idx", a, 32'd0);

        // Enable dropped in WAIT: write-back still happens, then fetching stops
        poke(8'd0, 32'h0004_C000);
        job(1'b0, 32'h50, 16'd4, 1'b0, 16'd0, 8'd0, 32'h0004_4000, 1'b1, 1'b0, "t6b");
        job(1'b0, 32'h60, 16'd6, 1'b0, 16'd0, 8'd2, 32'h0006_0000, 1'b0, 1'b1, "t7");
        snap_en = en_cnt;
        repeat (30) tick();
        check("t7_no_fetch", 32'(en_cnt - snap_en), 32'd0);
        check("t7_idle", 32'(busy_o), 32'd0);
        tx_en_i = 1'b1;
        wait_fetch(a);
        check("t7_reenable_idx", a, 32'd0);
        tx_en_i = 1'b0;
        wait_idle("t7_end_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
